// File: rtl/gpi_debounce_pkg.sv
// gpi_debounce_pkg: shared widths and defaults for the GPI debouncer
package gpi_debounce_pkg;

    localparam int DefaultDebounceCycles = 500000;
    localparam int NavSwWidth = 5;
    localparam int UsrSwWidth = 8;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// gpi_debounce_bit: single-bit synchroniser, stability counter and edge pulses
module gpi_debounce_bit
    import gpi_debounce_pkg::*;
#(
    parameter int   DebounceCycles = DefaultDebounceCycles,
    parameter logic ResetValue     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic fire_o
);

    localparam int CntW = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic db_q, db_d, rise_q, fall_q, mismatch, fire;

    assign mismatch = sync_q[1] != db_q;
    assign fire     = mismatch && (cnt_q == CntMax);

    // Any return to the debounced level abandons the count, so short bounces never fire
    always_comb begin
        cnt_d = (!mismatch || fire) ? '0 : cnt_q + 1'b1;
        db_d  = fire ? sync_q[1] : db_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{ResetValue}};
            cnt_q  <= '0;
            db_q   <= ResetValue;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= fire & sync_q[1];
            fall_q <= fire & ~sync_q[1];
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign fire_o = fire;

endmodule

// File: rtl/gpi_debounce.sv
// gpi_debounce: per-bit synchronise and debounce of board switches with rise/fall events
module gpi_debounce
    import gpi_debounce_pkg::*;
#(
    parameter int               Width          = NavSwWidth + UsrSwWidth,
    parameter int               DebounceCycles = DefaultDebounceCycles,
    parameter logic             InvertInputs   = 1'b1,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] db_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             change_o
);

    logic [Width-1:0] in_vec, fire;
    logic change_q;

    assign in_vec = raw_i ^ {Width{InvertInputs}};

    for (genvar i = 0; i < Width; i++) begin : g_bit
        gpi_debounce_bit #(
            .DebounceCycles(DebounceCycles),
            .ResetValue    (ResetValue[i])
        ) u_bit (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .in_i  (in_vec[i]),
            .db_o  (db_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i]),
            .fire_o(fire[i])
        );
    end

    // Registered from the same-cycle fire terms so it lines up with rise_o/fall_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) change_q <= 1'b0;
        else change_q <= |fire;
    end

    assign change_o = change_q;

endmodule

// File: doc/gpi_debounce.md
# gpi_debounce

Per-bit synchroniser and debouncer for the board's mechanical inputs: the 5-way navigation switch and the 8 user DIP switches. It sits between the FPGA pads and the system's `gp_i` input, and presents clean, active-high, glitch-free levels. It also emits single-cycle rise/fall event pulses, so software and peripherals never see contact bounce or metastable values.

## Interface
- `Width`, 13: number of independent input bits; must be ≥ 1.
- `DebounceCycles`, 500000: consecutive stable cycles required before the output follows the input (10 ms at 50 MHz); must be ≥ 1.
- `InvertInputs`, 1'b1: when 1, each raw bit is inverted before synchronisation. The switches have pull-ups and pull to ground when on, so the default makes a pressed switch read 1.
- `ResetValue`, '0: `Width`-bit value loaded into `db_o` and the synchroniser stages at reset (post-inversion domain).

Ports:
- `clk_i` input 1: system clock. This block has exactly one clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `raw_i` input `Width`: asynchronous pad inputs.
- `db_o` output `Width`: debounced, active-high levels.
- `rise_o` output `Width`: one-cycle pulse per bit when `db_o[i]` goes 0→1.
- `fall_o` output `Width`: one-cycle pulse per bit when `db_o[i]` goes 1→0.
- `change_o` output 1: OR-reduction of `rise_o | fall_o`, registered coincident with them.

## Operation
- Per bit i, define `in_i = raw_i[i] ^ InvertInputs`.
- `in_i` passes through a two-flop synchroniser to give `sync_q`.
- Each bit has a stability counter `cnt_q` of width `$clog2(DebounceCycles)`, with a minimum width of 1.
- Each bit behaves as a two-state machine, STABLE or PENDING, with the state implied by `cnt_q` and the mismatch signal. The rules are evaluated in this priority order at each edge:
  - `sync_q == db_q`: `cnt_q <= 0` (STABLE). Any in-progress count is abandoned, which rejects bounce glitches shorter than `DebounceCycles`.
  - `sync_q != db_q` and `cnt_q == DebounceCycles-1`: `db_q <= sync_q`, `cnt_q <= 0`, and either `rise_q` (new value 1) or `fall_q` (new value 0) is set for one cycle.
  - `sync_q != db_q` otherwise: `cnt_q <= cnt_q + 1` (PENDING).
- The counter saturates by construction: it never exceeds `DebounceCycles-1` and never wraps.
- `rise_o` and `fall_o` are registered, are high for exactly one cycle, and are never both high for the same bit.
- Bits are fully independent. Simultaneous transitions on several bits give simultaneous pulses, and `change_o` is a single cycle.
- When `DebounceCycles == 1`, the block degenerates to a synchroniser plus one register stage.

## Timing
- Reset values:
  - `db_o = ResetValue`
  - synchroniser flops = `ResetValue`
  - `cnt_q = 0`
  - `rise_o = fall_o = 0`
  - `change_o = 0`
- No event pulse is generated on reset release, even if the inputs differ from `ResetValue`; the normal debounce path applies afterwards.
- Latency: number the first `clk_i` edge that samples a new stable level as edge 1. `db_o`, `rise_o`/`fall_o` and `change_o` update at edge `DebounceCycles + 2`.
- `rise_o`/`fall_o` drop at the following edge.
- A reversal of `sync_q` back to `db_q` before the final edge clears the counter. No output change and no pulse occur.
- Asserting reset mid-count clears all state immediately, without waiting for a clock edge. Counting restarts from 0 after deassertion.
- Deassertion of `rst_ni` is already synchronised by the system reset controller. This block does not re-synchronise it.

## Structure
- Shared package `gpi_debounce_pkg` holds:
  - `DefaultDebounceCycles = 500000`
  - `NavSwWidth = 5` and `UsrSwWidth = 8`, so the top-level `gp_i` concatenation is built from named widths.
- Sub-module `gpi_debounce_bit`: single-bit synchroniser, counter, and edge detection. It is instantiated `Width` times in a generate loop.
- The top module only inverts inputs, builds the per-bit vectors, and registers `change_o`.
- Synchroniser flops carry the team's standard async-register attribute.

## Test plan
Benches use `DebounceCycles = 4` and `Width = 13`.
- **Clean press:**
  - `raw_i[0]` held 0 (pressed, inverted), all others 1 → `db_o[0]` goes 1 at edge 6.
  - `rise_o[0]` and `change_o` are high for that single cycle.
  - All other bits stay 0.
- **Bounce rejection:** toggle `raw_i[3]` every 2 cycles for 20 cycles, then hold it pressed → no pulse during bouncing; `db_o[3]` goes 1 exactly 6 edges after the final transition.
- **Release:** from `db_o[5] = 1`, raise `raw_i[5]` → `db_o[5]` goes 0 at edge 6, with a single `fall_o[5]` pulse and no `rise_o` activity.
- **Simultaneous:** press bits 0, 7 and 12 on the same cycle → `rise_o = 13'h1081` for one cycle and `change_o` is high for one cycle.
- **Reset mid-count:** press bit 2 and assert `rst_ni = 0` after 3 cycles → `db_o`, `cnt_q` and all pulses are 0 immediately. After release with the switch still held, `db_o[2]` goes 1 at edge 6 after release and a single `rise_o[2]` is produced.
- **Reset value and no spurious pulse:** with `ResetValue = 13'h0001` and all switches off → `db_o = 1` during reset. After release, `fall_o[0]` pulses at edge 6, with no earlier pulse.
